// File: rtl/regfile_driver.sv
// Initiator-side controller for a 2R/1W register file: queued writes, fixed-latency reads, pairwise scan.
// Build option: REGFILE_DRIVER_ZERO_GUARD_EN drops writes to register 0 at issue time.
module regfile_driver #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int WQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_req_valid,
   output logic              wr_req_ready,
   input  logic [ADDR_W-1:0] wr_req_addr,
   input  logic [DATA_W-1:0] wr_req_data,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [ADDR_W-1:0] rd_req_addr1,
   input  logic [ADDR_W-1:0] rd_req_addr2,
   output logic              rd_rsp_valid,
   output logic [ADDR_W-1:0] rd_rsp_addr1,
   output logic [ADDR_W-1:0] rd_rsp_addr2,
   output logic [DATA_W-1:0] rd_rsp_data1,
   output logic [DATA_W-1:0] rd_rsp_data2,
   input  logic              scan_start,
   output logic              scan_busy,
   output logic              scan_done,
   output logic [ADDR_W-1:0] rf_addr1,
   output logic [ADDR_W-1:0] rf_addr2,
   input  logic [DATA_W-1:0] rf_out1,
   input  logic [DATA_W-1:0] rf_out2,
   output logic [ADDR_W-1:0] rf_write_at_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_write_enable
);

   localparam int PTR_W = $clog2(WQ_DEPTH);
   localparam int K_W   = (NUM_REGS > 2) ? $clog2(NUM_REGS / 2) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(NUM_REGS / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SCAN, S_DONE} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_ent_t;

   state_t state, state_nxt;

   wr_ent_t          wq [WQ_DEPTH];
   wr_ent_t          head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             full, empty, push, pop, issue_en, head_ok;

   logic [K_W-1:0]    k;
   logic              rd_fire;
   logic              a_vld;
   logic [ADDR_W-1:0] a_addr1, a_addr2;
   logic              addr_vld, addr_last, rsp_last;

   // ---------------- write queue ----------------
   assign full         = (count == (PTR_W+1)'(WQ_DEPTH));
   assign empty        = (count == '0);
   assign wr_req_ready = !full;
   assign push         = wr_req_valid && !full;
   // Writes that arrive once the scan has started stay queued until the FSM returns to idle.
   assign issue_en     = (state == S_IDLE) || (state == S_DRAIN);
   assign pop          = issue_en && !empty;
   assign head         = wq[rd_ptr];

`ifdef REGFILE_DRIVER_ZERO_GUARD_EN
   assign head_ok = (head.addr != '0);
`else
   assign head_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (push) wq[wr_ptr] <= '{addr: wr_req_addr, data: wr_req_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         rf_write_enable  <= 1'b0;
         rf_write_at_addr <= '0;
         rf_write_data    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count           <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
         rf_write_enable <= pop && head_ok;
         if (pop) begin
            rf_write_at_addr <= head.addr;
            rf_write_data    <= head.data;
         end
      end
   end

   // ---------------- read path ----------------
   // Nothing may be pending toward the file, so a read always sees every earlier write.
   assign rd_req_ready = (state == S_IDLE) && empty && !rf_write_enable;
   assign rd_fire      = rd_req_valid && rd_req_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_vld        <= 1'b0;
         a_addr1      <= '0;
         a_addr2      <= '0;
         addr_vld     <= 1'b0;
         addr_last    <= 1'b0;
         rf_addr1     <= '0;
         rf_addr2     <= '0;
         rd_rsp_valid <= 1'b0;
         rsp_last     <= 1'b0;
         rd_rsp_addr1 <= '0;
         rd_rsp_addr2 <= '0;
         rd_rsp_data1 <= '0;
         rd_rsp_data2 <= '0;
      end else begin
         a_vld <= rd_fire;
         if (rd_fire) begin
            a_addr1 <= rd_req_addr1;
            a_addr2 <= rd_req_addr2;
         end
         if (state == S_SCAN) begin
            rf_addr1  <= ADDR_W'({k, 1'b0});
            rf_addr2  <= ADDR_W'({k, 1'b1});
            addr_vld  <= 1'b1;
            addr_last <= (k == K_LAST);
         end else begin
            addr_vld  <= a_vld;
            addr_last <= 1'b0;
            if (a_vld) begin
               rf_addr1 <= a_addr1;
               rf_addr2 <= a_addr2;
            end
         end
         rd_rsp_valid <= addr_vld;
         rsp_last     <= addr_vld && addr_last;
         if (addr_vld) begin
            rd_rsp_addr1 <= rf_addr1;
            rd_rsp_addr2 <= rf_addr2;
            rd_rsp_data1 <= rf_out1;
            rd_rsp_data2 <= rf_out2;
         end
      end
   end

   // ---------------- scan FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         k         <= '0;
         scan_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         scan_done <= (state == S_DONE) && rsp_last;
         if (state == S_SCAN) k <= k + 1'b1;
         else                 k <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (scan_start) state_nxt = S_DRAIN;
         S_DRAIN: if (empty && !rf_write_enable) state_nxt = S_SCAN;
         S_SCAN:  if (k == K_LAST) state_nxt = S_DONE;
         // Hold until the last pair's response is on the outputs so scan_done trails it by one cycle.
         S_DONE:  if (rsp_last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign scan_busy = (state == S_DRAIN) || (state == S_SCAN);

endmodule

// File: tb/tb_regfile_driver.sv
// Bench for regfile_driver: behavioural register-file model, directed vector table, scan/reset sequences, random traffic.
module tb_regfile_driver;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;
`ifdef REGFILE_DRIVER_ZERO_GUARD_EN
   localparam bit ZG = 1'b1;
`else
   localparam bit ZG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_req_valid, wr_req_ready;
   logic [AW-1:0] wr_req_addr;
   logic [DW-1:0] wr_req_data;
   logic          rd_req_valid, rd_req_ready;
   logic [AW-1:0] rd_req_addr1, rd_req_addr2;
   logic          rd_rsp_valid;
   logic [AW-1:0] rd_rsp_addr1, rd_rsp_addr2;
   logic [DW-1:0] rd_rsp_data1, rd_rsp_data2;
   logic          scan_start, scan_busy, scan_done;
   logic [AW-1:0] rf_addr1, rf_addr2, rf_write_at_addr;
   logic [DW-1:0] rf_out1, rf_out2, rf_write_data;
   logic          rf_write_enable;

   regfile_driver #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WQ_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
      .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_req_addr1(rd_req_addr1), .rd_req_addr2(rd_req_addr2),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_addr1(rd_rsp_addr1), .rd_rsp_addr2(rd_rsp_addr2),
      .rd_rsp_data1(rd_rsp_data1), .rd_rsp_data2(rd_rsp_data2),
      .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
      .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_out1(rf_out1), .rf_out2(rf_out2),
      .rf_write_at_addr(rf_write_at_addr), .rf_write_data(rf_write_data),
      .rf_write_enable(rf_write_enable)
   );

   always #5 clk = ~clk;

   // The register file itself: combinational reads, write on the clock edge.
   logic [DW-1:0] rf [NR] = '{default: '0};
   always @(posedge clk) if (rf_write_enable) rf[rf_write_at_addr] <= rf_write_data;
   assign rf_out1 = rf[rf_addr1];
   assign rf_out2 = rf[rf_addr2];

   typedef struct {
      int            due;
      logic [AW-1:0] a1, a2;
      logic [DW-1:0] d1, d2;
   } rsp_t;

   typedef struct {
      bit            is_wr;
      logic [AW-1:0] a1, a2;
      logic [DW-1:0] wdata, e1, e2;
      int            stall;
   } vec_t;

   logic [DW-1:0] model [NR];
   logic [DW-1:0] model_bak [NR];
   rsp_t rdq[$];
   rsp_t scq[$];
   int   n_vec = 0, n_bad = 0, cyc = 0;
   bit   last_fire_rd, last_fire_wr;
   int   scan_rsp_cnt, last_scan_cyc, done_cnt, done_cyc, we_cnt;
   logic [DW-1:0] pair1_d2, pair15_d2;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: decide handshakes from pre-edge state, advance the model, then check outputs after the edge.
   task automatic tick();
      bit   frd, fwr;
      rsp_t e;
      frd = rd_req_valid && rd_req_ready && !reset;
      fwr = wr_req_valid && wr_req_ready && !reset;
      if (frd) rdq.push_back('{cyc + 3, rd_req_addr1, rd_req_addr2, model[rd_req_addr1], model[rd_req_addr2]});
      if (fwr && !(ZG && wr_req_addr == '0)) model[wr_req_addr] = wr_req_data;
      @(posedge clk);
      #1;
      cyc++;
      last_fire_rd = frd;
      last_fire_wr = fwr;
      if (reset) begin
         rdq.delete();
         scq.delete();
      end else begin
         if (rdq.size() != 0 && rdq[0].due == cyc) begin
            e = rdq.pop_front();
            chk("rd_rsp", {rd_rsp_valid, rd_rsp_addr1, rd_rsp_addr2, rd_rsp_data1, rd_rsp_data2},
                          {1'b1, e.a1, e.a2, e.d1, e.d2});
         end else if (rd_rsp_valid) begin
            if (scq.size() != 0) begin
               e = scq.pop_front();
               chk("scan_rsp", {rd_rsp_addr1, rd_rsp_addr2, rd_rsp_data1, rd_rsp_data2},
                               {e.a1, e.a2, e.d1, e.d2});
               scan_rsp_cnt++;
               last_scan_cyc = cyc;
               if (e.a1 == 5'd2)  pair1_d2  = rd_rsp_data2;
               if (e.a1 == 5'd30) pair15_d2 = rd_rsp_data2;
            end else chk("spurious_rsp", rd_rsp_valid, 1'b0);
         end
         if (scan_busy) chk("wr_held_in_scan", rf_write_enable, 1'b0);
         if (scan_done) begin done_cnt++; done_cyc = cyc; end
         if (rf_write_enable) we_cnt++;
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      wr_req_valid = 1'b1; wr_req_addr = a; wr_req_data = d;
      n = 0;
      tick();
      while (!last_fire_wr && n < 60) begin n++; tick(); end
      chk("wr_accept", last_fire_wr, 1'b1);
      wr_req_valid = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2, output int stalls);
      rd_req_valid = 1'b1; rd_req_addr1 = a1; rd_req_addr2 = a2;
      stalls = 0;
      tick();
      while (!last_fire_rd && stalls < 60) begin stalls++; tick(); end
      chk("rd_accept", last_fire_rd, 1'b1);
      rd_req_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic start_scan();
      for (int i = 0; i < NR / 2; i++)
         scq.push_back('{0, AW'(2 * i), AW'(2 * i + 1), model[2 * i], model[2 * i + 1]});
      scan_rsp_cnt = 0;
      done_cnt     = 0;
      scan_start   = 1'b1;
      tick();
      scan_start   = 1'b0;
   endtask

   task automatic wait_scan_rsp();
      int n = 0;
      while (scan_rsp_cnt == 0 && n < 40) begin n++; tick(); end
      chk("scan_started", scan_rsp_cnt != 0, 1'b1);
   endtask

   task automatic finish_scan();
      int n = 0;
      while (done_cnt == 0 && n < 60) begin n++; tick(); end
      repeat (3) tick();
      chk("scan_rsp_count", scan_rsp_cnt, NR / 2);
      chk("scan_done_pulses", done_cnt, 1);
      chk("scan_done_lag", done_cyc - last_scan_cyc, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vt[10];
      int   st;
      logic [DW-1:0] saved5, saved6;

      vt[0] = '{1'b1, 5'd10, 5'd0,  32'd10,  32'd0,   32'd0,   0};
      vt[1] = '{1'b0, 5'd8,  5'd10, 32'd0,   32'd0,   32'd10,  2};
      vt[2] = '{1'b1, 5'd8,  5'd0,  32'd8,   32'd0,   32'd0,   0};
      vt[3] = '{1'b1, 5'd8,  5'd0,  32'd256, 32'd0,   32'd0,   0};
      vt[4] = '{1'b0, 5'd8,  5'd8,  32'd0,   32'd256, 32'd256, 2};
      vt[5] = '{1'b1, 5'd3,  5'd0,  32'd3,   32'd0,   32'd0,   0};
      vt[6] = '{1'b1, 5'd31, 5'd0,  32'd31,  32'd0,   32'd0,   0};
      vt[7] = '{1'b0, 5'd3,  5'd31, 32'd0,   32'd3,   32'd31,  2};
      vt[8] = '{1'b1, 5'd0,  5'd0,  32'd5,   32'd0,   32'd0,   0};
      vt[9] = '{1'b0, 5'd0,  5'd0,  32'd0,   ZG ? 32'd0 : 32'd5, ZG ? 32'd0 : 32'd5, ZG ? 1 : 2};

      for (int i = 0; i < NR; i++) model[i] = '0;
      reset = 1'b1; wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
      rd_req_valid = 1'b0; rd_req_addr1 = '0; rd_req_addr2 = '0; scan_start = 1'b0;

      repeat (3) tick();
      chk("rst_rsp", {rd_rsp_valid, rd_rsp_addr1, rd_rsp_addr2, rd_rsp_data1, rd_rsp_data2}, '0);
      chk("rst_rf", {rf_addr1, rf_addr2, rf_write_at_addr, rf_write_data, rf_write_enable}, '0);
      chk("rst_scan", {scan_busy, scan_done}, 2'b00);
      chk("rst_ready", {wr_req_ready, rd_req_ready}, 2'b11);
      reset = 1'b0;

      // Directed table (register 0 row last so the scan below sees it untouched).
      for (int i = 0; i < 8; i++) begin
         if (vt[i].is_wr) do_write(vt[i].a1, vt[i].wdata);
         else begin
            do_read(vt[i].a1, vt[i].a2, st);
            chk("tbl_rd", {rd_rsp_valid, rd_rsp_data1, rd_rsp_data2}, {1'b1, vt[i].e1, vt[i].e2});
            chk("tbl_stall", st, vt[i].stall);
         end
      end

      // Full scan: pairs in order, known values in pairs 1 and 15.
      start_scan();
      finish_scan();
      chk("pair1_data2", pair1_d2, 32'd3);
      chk("pair15_data2", pair15_d2, 32'd31);

      // Five writes issued during a scan: the queue holds four, the fifth waits for the first pop.
      start_scan();
      wait_scan_rsp();
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            chk("wq_full_ready", wr_req_ready, 1'b0);
            chk("wq_full_busy", scan_busy, 1'b1);
         end
         do_write(AW'(20 + i), $urandom);
         if (i == 4) chk("fifth_after_done", done_cnt, 1);
      end
      finish_scan();
      do_read(5'd20, 5'd21, st);
      do_read(5'd22, 5'd23, st);
      do_read(5'd24, 5'd24, st);

      // Reset in the middle of a scan with two held writes.
      model_bak = model;
      saved5 = model[5];
      saved6 = model[6];
      start_scan();
      wait_scan_rsp();
      do_write(5'd5, 32'hDEAD_0005);
      do_write(5'd6, 32'hDEAD_0006);
      tick();
      reset = 1'b1;
      tick();
      chk("midrst_state", {scan_busy, scan_done, rd_rsp_valid, rf_write_enable, wr_req_ready, rd_req_ready},
                          6'b000011);
      reset = 1'b0;
      model = model_bak;
      done_cnt = 0;
      we_cnt   = 0;
      repeat (25) tick();
      chk("midrst_no_done", done_cnt, 0);
      chk("midrst_no_write", we_cnt, 0);
      chk("midrst_rf5", rf[5], saved5);
      chk("midrst_rf6", rf[6], saved6);
      do_read(5'd5, 5'd6, st);

      // Register 0 behaviour depends on the build option.
      for (int i = 8; i < 10; i++) begin
         if (vt[i].is_wr) do_write(vt[i].a1, vt[i].wdata);
         else begin
            do_read(vt[i].a1, vt[i].a2, st);
            chk("tbl_rd", {rd_rsp_valid, rd_rsp_data1, rd_rsp_data2}, {1'b1, vt[i].e1, vt[i].e2});
            chk("tbl_stall", st, vt[i].stall);
         end
      end

      // Random mixed traffic against the model.
      for (int t = 0; t < 600; t++) begin
         wr_req_valid = ($urandom_range(0, 3) == 0);
         wr_req_addr  = AW'($urandom);
         wr_req_data  = $urandom;
         rd_req_valid = ($urandom_range(0, 2) != 0);
         rd_req_addr1 = AW'($urandom);
         rd_req_addr2 = ($urandom_range(0, 3) == 0) ? rd_req_addr1 : AW'($urandom);
         tick();
      end
      wr_req_valid = 1'b0;
      rd_req_valid = 1'b0;
      repeat (8) tick();
      chk("rdq_drained", rdq.size(), 0);
      chk("scq_drained", scq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
